// File: rtl/control_sequencer_if.sv
// Control bundle between the Mini-SRC sequencer and its datapath.
// The sequencer (master) reads IR and drives every datapath strobe.
interface control_sequencer_if #(
    parameter int OP_W  = 5,
    parameter int NREGS = 16
);
    logic [31:0]      IR;
    logic [NREGS-1:0] Rin;
    logic [NREGS-1:0] Rout;
    logic             PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic             Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic [OP_W-1:0]  ALU_Control;
    logic             run;
    logic [2:0]       step;

    modport master (
        input  IR,
        output Rin, Rout, PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
        output Yin, Zin, Zlowout, Zhighout, HIin, LOin, ALU_Control, run, step
    );

    modport slave (
        output IR,
        input  Rin, Rout, PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
        input  Yin, Zin, Zlowout, Zhighout, HIin, LOin, ALU_Control, run, step
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the Mini-SRC datapath: steps T0..T6
// and decodes the control strobes from the current step and IR fields.
module control_sequencer #(
    parameter int OP_W  = 5,
    parameter int NREGS = 16
) (
    input  logic clock,
    input  logic clear,
    control_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
        T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, HALT = 3'd7
    } state_t;

    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(5'b01110);
    localparam logic [OP_W-1:0] OP_DIV  = OP_W'(5'b01111);
    localparam logic [OP_W-1:0] OP_NEG  = OP_W'(5'b10000);
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(5'b10001);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(5'b11011);
    localparam logic [NREGS-1:0] ONE    = NREGS'(1);

    state_t state, state_nxt;

    logic [OP_W-1:0]  op;
    logic [NREGS-1:0] ra_oh, rb_oh, rc_oh;
    logic             is_alu, is_muldiv, is_unary, is_halt;
    logic             unused_ir;

    assign op        = bus.IR[31 -: OP_W];
    assign ra_oh     = ONE << bus.IR[26:23];
    assign rb_oh     = ONE << bus.IR[22:19];
    assign rc_oh     = ONE << bus.IR[18:15];
    assign unused_ir = ^bus.IR[14:0];

    // add..shl occupy one contiguous opcode range
    assign is_alu    = (op >= OP_W'(5'b00011)) && (op <= OP_W'(5'b01011));
    assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    assign is_unary  = (op == OP_NEG) || (op == OP_NOT);
    assign is_halt   = (op == OP_HALT);

    always_ff @(posedge clock) begin
        if (clear) state <= T0;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = T0;
        case (state)
            T0:   state_nxt = T1;
            T1:   state_nxt = T2;
            T2:   state_nxt = T3;
            T3: begin
                if (is_alu || is_muldiv || is_unary) state_nxt = T4;
                else if (is_halt)                    state_nxt = HALT;
                else                                 state_nxt = T0;
            end
            T4:   state_nxt = (is_alu || is_muldiv) ? T5 : T0;
            T5:   state_nxt = is_muldiv ? T6 : T0;
            T6:   state_nxt = T0;
            HALT: state_nxt = HALT;
            default: state_nxt = T0;
        endcase
    end

    assign bus.step = state;
    assign bus.run  = (state != HALT);

    always_comb begin
        bus.Rin = '0;  bus.Rout = '0;  bus.ALU_Control = '0;
        bus.PCout = 1'b0; bus.PCin = 1'b0; bus.IncPC = 1'b0; bus.MARin = 1'b0;
        bus.Read = 1'b0;  bus.MDRin = 1'b0; bus.MDRout = 1'b0; bus.IRin = 1'b0;
        bus.Yin = 1'b0;   bus.Zin = 1'b0;  bus.Zlowout = 1'b0; bus.Zhighout = 1'b0;
        bus.HIin = 1'b0;  bus.LOin = 1'b0;
        // clear forces a quiet bus even mid-instruction
        if (!clear) begin
            case (state)
                T0: begin
                    bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
                end
                T1: begin
                    bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
                end
                T2: begin
                    bus.MDRout = 1'b1; bus.IRin = 1'b1;
                end
                T3: begin
                    if (is_alu) begin
                        bus.Rout = rb_oh; bus.Yin = 1'b1;
                    end else if (is_muldiv) begin
                        bus.Rout = ra_oh; bus.Yin = 1'b1;
                    end else if (is_unary) begin
                        bus.Rout = rb_oh; bus.Zin = 1'b1; bus.ALU_Control = op;
                    end
                end
                T4: begin
                    if (is_alu) begin
                        bus.Rout = rc_oh; bus.Zin = 1'b1; bus.ALU_Control = op;
                    end else if (is_muldiv) begin
                        bus.Rout = rb_oh; bus.Zin = 1'b1; bus.ALU_Control = op;
                    end else if (is_unary) begin
                        bus.Zlowout = 1'b1; bus.Rin = ra_oh;
                    end
                end
                T5: begin
                    if (is_alu) begin
                        bus.Zlowout = 1'b1; bus.Rin = ra_oh;
                    end else if (is_muldiv) begin
                        bus.Zlowout = 1'b1; bus.LOin = 1'b1;
                    end
                end
                T6: begin
                    bus.Zhighout = 1'b1; bus.HIin = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a table of per-cycle vectors
// followed by hand-written halt-hold and mid-instruction clear sequences.
module tb_control_sequencer;
    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    control_sequencer_if bus ();
    control_sequencer dut (.clock(clock), .clear(clear), .bus(bus));

    int checks = 0;
    int failures = 0;

    // strobe vector order: PCout PCin IncPC MARin Read MDRin MDRout IRin Yin Zin Zlowout Zhighout HIin LOin
    localparam logic [13:0] PCOUT = 14'h2000, PCIN = 14'h1000, INCPC = 14'h0800, MARIN = 14'h0400;
    localparam logic [13:0] READ = 14'h0200, MDRIN = 14'h0100, MDROUT = 14'h0080, IRIN = 14'h0040;
    localparam logic [13:0] YIN = 14'h0020, ZIN = 14'h0010, ZLO = 14'h0008, ZHI = 14'h0004;
    localparam logic [13:0] HIIN = 14'h0002, LOIN = 14'h0001;
    localparam logic [13:0] F0 = PCOUT | MARIN | INCPC | ZIN;
    localparam logic [13:0] F1 = ZLO | PCIN | READ | MDRIN;
    localparam logic [13:0] F2 = MDROUT | IRIN;

    localparam logic [31:0] IR_ROR  = 32'h3A2B0000; // ror R4,R5,R6
    localparam logic [31:0] IR_ADD  = 32'h19110000; // add R2,R2,R2
    localparam logic [31:0] IR_MUL  = 32'h71880000; // mul R3,R1
    localparam logic [31:0] IR_NEG  = 32'h80B80000; // neg R1,R7
    localparam logic [31:0] IR_UND  = 32'hF8000000; // opcode 11111
    localparam logic [31:0] IR_HALT = 32'hD8000000;

    typedef struct {
        logic        clr;
        logic [31:0] ir;
        logic [54:0] exp;
        string       name;
    } vec_t;

    vec_t vq[$];
    logic [13:0] stb;

    assign stb = {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.Read, bus.MDRin,
                  bus.MDRout, bus.IRin, bus.Yin, bus.Zin, bus.Zlowout, bus.Zhighout,
                  bus.HIin, bus.LOin};

    function automatic logic [54:0] ex(input logic [2:0] st, input logic rn,
                                       input logic [15:0] ri, input logic [15:0] ro,
                                       input logic [13:0] sb, input logic [4:0] alu);
        return {st, rn, ri, ro, sb, alu};
    endfunction

    task automatic check(input string nm, input logic [54:0] e);
        logic [54:0] o;
        o = {bus.step, bus.run, bus.Rin, bus.Rout, stb, bus.ALU_Control};
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL %s got step=%0d run=%b Rin=%h Rout=%h stb=%h alu=%b exp step=%0d run=%b Rin=%h Rout=%h stb=%h alu=%b",
                     nm, o[54:52], o[51], o[50:35], o[34:19], o[18:5], o[4:0],
                     e[54:52], e[51], e[50:35], e[34:19], e[18:5], e[4:0]);
        end
    endtask

    task automatic cyc(input logic clr, input logic [31:0] ir, input string nm, input logic [54:0] e);
        clear  = clr;
        bus.IR = ir;
        @(negedge clock);
        check(nm, e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear  = 1'b1;
        bus.IR = '0;
        @(posedge clock);
        #1;

        vq.push_back('{1'b1, IR_ROR, ex(0, 1, 0, 0, 0, 0), "clear_quiet"});
        vq.push_back('{1'b0, IR_ROR, ex(0, 1, 0, 0, F0, 0), "ror_T0"});
        vq.push_back('{1'b0, IR_ROR, ex(1, 1, 0, 0, F1, 0), "ror_T1"});
        vq.push_back('{1'b0, IR_ROR, ex(2, 1, 0, 0, F2, 0), "ror_T2"});
        vq.push_back('{1'b0, IR_ROR, ex(3, 1, 0, 16'h0020, YIN, 0), "ror_T3"});
        vq.push_back('{1'b0, IR_ROR, ex(4, 1, 0, 16'h0040, ZIN, 5'b00111), "ror_T4"});
        vq.push_back('{1'b0, IR_ROR, ex(5, 1, 16'h0010, 0, ZLO, 0), "ror_T5"});
        vq.push_back('{1'b0, IR_ADD, ex(0, 1, 0, 0, F0, 0), "add_T0"});
        vq.push_back('{1'b0, IR_ADD, ex(1, 1, 0, 0, F1, 0), "add_T1"});
        vq.push_back('{1'b0, IR_ADD, ex(2, 1, 0, 0, F2, 0), "add_T2"});
        vq.push_back('{1'b0, IR_ADD, ex(3, 1, 0, 16'h0004, YIN, 0), "add_T3"});
        vq.push_back('{1'b0, IR_ADD, ex(4, 1, 0, 16'h0004, ZIN, 5'b00011), "add_T4"});
        vq.push_back('{1'b0, IR_ADD, ex(5, 1, 16'h0004, 0, ZLO, 0), "add_T5"});
        vq.push_back('{1'b0, IR_MUL, ex(0, 1, 0, 0, F0, 0), "mul_T0"});
        vq.push_back('{1'b0, IR_MUL, ex(1, 1, 0, 0, F1, 0), "mul_T1"});
        vq.push_back('{1'b0, IR_MUL, ex(2, 1, 0, 0, F2, 0), "mul_T2"});
        vq.push_back('{1'b0, IR_MUL, ex(3, 1, 0, 16'h0008, YIN, 0), "mul_T3"});
        vq.push_back('{1'b0, IR_MUL, ex(4, 1, 0, 16'h0002, ZIN, 5'b01110), "mul_T4"});
        vq.push_back('{1'b0, IR_MUL, ex(5, 1, 0, 0, ZLO | LOIN, 0), "mul_T5"});
        vq.push_back('{1'b0, IR_MUL, ex(6, 1, 0, 0, ZHI | HIIN, 0), "mul_T6"});
        vq.push_back('{1'b0, IR_NEG, ex(0, 1, 0, 0, F0, 0), "neg_T0"});
        vq.push_back('{1'b0, IR_NEG, ex(1, 1, 0, 0, F1, 0), "neg_T1"});
        vq.push_back('{1'b0, IR_NEG, ex(2, 1, 0, 0, F2, 0), "neg_T2"});
        vq.push_back('{1'b0, IR_NEG, ex(3, 1, 0, 16'h0080, ZIN, 5'b10000), "neg_T3"});
        vq.push_back('{1'b0, IR_NEG, ex(4, 1, 16'h0002, 0, ZLO, 0), "neg_T4"});
        vq.push_back('{1'b0, IR_UND, ex(0, 1, 0, 0, F0, 0), "und_T0"});
        vq.push_back('{1'b0, IR_UND, ex(1, 1, 0, 0, F1, 0), "und_T1"});
        vq.push_back('{1'b0, IR_UND, ex(2, 1, 0, 0, F2, 0), "und_T2"});
        vq.push_back('{1'b0, IR_UND, ex(3, 1, 0, 0, 0, 0), "und_T3"});
        vq.push_back('{1'b0, IR_HALT, ex(0, 1, 0, 0, F0, 0), "halt_T0"});
        vq.push_back('{1'b0, IR_HALT, ex(1, 1, 0, 0, F1, 0), "halt_T1"});
        vq.push_back('{1'b0, IR_HALT, ex(2, 1, 0, 0, F2, 0), "halt_T2"});
        vq.push_back('{1'b0, IR_HALT, ex(3, 1, 0, 0, 0, 0), "halt_T3"});

        foreach (vq[i]) cyc(vq[i].clr, vq[i].ir, vq[i].name, vq[i].exp);

        // halted: IR changes must not wake the sequencer
        for (int i = 0; i < 20; i++)
            cyc(1'b0, (i % 2 == 0) ? IR_ADD : IR_MUL, "halt_hold", ex(7, 0, 0, 0, 0, 0));
        cyc(1'b1, IR_ADD, "halt_clear", ex(7, 0, 0, 0, 0, 0));

        // restart, then abort the add at T4 with clear
        cyc(1'b0, IR_ADD, "restart_T0", ex(0, 1, 0, 0, F0, 0));
        cyc(1'b0, IR_ADD, "restart_T1", ex(1, 1, 0, 0, F1, 0));
        cyc(1'b0, IR_ADD, "restart_T2", ex(2, 1, 0, 0, F2, 0));
        cyc(1'b0, IR_ADD, "restart_T3", ex(3, 1, 0, 16'h0004, YIN, 0));
        cyc(1'b1, IR_ADD, "abort_T4", ex(4, 1, 0, 0, 0, 0));
        cyc(1'b0, IR_ADD, "abort_T0", ex(0, 1, 0, 0, F0, 0));
        cyc(1'b0, IR_ADD, "abort_T1", ex(1, 1, 0, 0, F1, 0));
        cyc(1'b0, IR_ADD, "abort_T2", ex(2, 1, 0, 0, F2, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
